trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
- Synthesisable, parametrised execution-trace recorder that replaces ad-hoc simulation printing of pc/register values on instruction retire.
- Sits beside the cpu: samples a retire strobe plus CHANNELS probe words (pc, ra, sp, a1...) into a circular buffer with a cycle stamp.
- Freezes a pre/post-trigger window and streams it out oldest-first over a valid/ready port, for uart dump or bench checking.

Parameters:
WIDTH, 32, bits per probe channel
CHANNELS, 4, probe channels per sample (>=1)
DEPTH, 64, buffer entries; power of 2, >=4
POST_TRIG, 16, samples stored after the trigger sample; 0 <= POST_TRIG < DEPTH
STAMP_W, 16, sample stamp counter width

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
arm  in  1  pulse: clear buffer and start capture
samp_valid  in  1  retire strobe; one sample per high cycle
samp_data  in  CHANNELS*WIDTH  probe words, channel 0 in LSBs
trig_in  in  1  trigger qualifier, meaningful only with samp_valid
dump  in  1  pulse: start readout (honoured only in DONE)
rd_valid  out  1  rd_data holds a valid entry
rd_ready  in  1  consumer accepts entry
rd_data  out  STAMP_W+CHANNELS*WIDTH  {stamp, samp_data}
rd_last  out  1  high with the final entry of a dump
state  out  3  IDLE=0 ARMED=1 POST=2 DONE=3 DUMP=4
fill  out  log2(DEPTH)+1  stored entries, 0..DEPTH

Behaviour:
- Reset (async assert, sync release): state=IDLE, rd_valid=0, rd_last=0, rd_data=0, fill=0, write pointer=0, stamp=0, post counter=0. Buffer contents undefined and never exposed.
- Stamp counts stored samples from 0; wraps modulo 2^STAMP_W; zeroed on arm.
- IDLE: samples ignored. arm -> ARMED.
- ARMED: each samp_valid writes {stamp, samp_data} at wr_ptr; wr_ptr increments mod DEPTH; fill saturates at DEPTH; once full, the oldest entry is overwritten.
- Trigger = samp_valid && trig_in in ARMED. The trigger sample is stored, then:
  - POST_TRIG=0 -> DONE.
  - otherwise -> POST with post counter = POST_TRIG.
- trig_in without samp_valid has no effect. trig_in in any state other than ARMED has no effect.
- POST: each samp_valid stores a sample and decrements the counter. On the store that reaches 0 -> DONE; that sample is stored.
- DONE: samples ignored; buffer frozen.
- dump in DONE -> DUMP. Read pointer = oldest entry: wr_ptr if fill==DEPTH, else 0. dump in any other state is ignored.
- DUMP:
  - rd_valid rises no later than 2 cycles after dump.
  - Entries are presented oldest-first. A transfer occurs on rd_valid && rd_ready.
  - rd_data and rd_last are held stable while rd_valid && !rd_ready.
  - Zero-bubble streaming is required when rd_ready is held high: one entry per cycle after the first.
  - rd_last is high only on entry number fill.
  - On the rd_last transfer: rd_valid=0 the next cycle, state -> IDLE, fill is kept until the next arm.
- DONE with fill=0 cannot occur: the trigger sample is always stored.
- arm in IDLE/ARMED/POST/DONE restarts: fill=0, wr_ptr=0, stamp=0 -> ARMED. A samp_valid in the same cycle as arm is not stored.
- arm during DUMP is ignored; dump must complete or reset must be asserted.
- samp_valid during DUMP is ignored.
- Reset asserted mid-operation (any state, including mid-dump) returns every output to its reset value immediately.
- Buffer is a single-port-write, single-port-read synchronous RAM, inferable as block RAM. Read prefetch must hide the one-cycle RAM latency so the zero-bubble requirement holds.

Test Plan:
All scenarios use DEPTH=8, POST_TRIG=3, CHANNELS=2, WIDTH=8, STAMP_W=16.
1. Reset, then idle 10 cycles with samp_valid=1 -> state=0, fill=0, rd_valid=0. dump ignored.
2. No wrap: arm; 6 samples data {ch1,ch0}={k,k}, k=1..6, trig_in on k=2 -> DONE after k=5, fill=5, k=6 not stored. dump with rd_ready=1 -> 5 consecutive beats, stamps 0..4, data 1..5, rd_last on stamp 4, then state=0.
3. Wrap: arm; 24 samples, trig_in on sample stamp 20 -> DONE after stamp 23, fill=8. Dump yields stamps 16..23 in order, rd_last on 23.
4. Backpressure: repeat scenario 2 with rd_ready toggling 1,0,0,1,... -> identical beat sequence. rd_data/rd_last stable during stalls. No duplicated or dropped entries.
5. Trigger qualification: pulse trig_in with samp_valid=0 -> stays ARMED. POST_TRIG=0 build: trigger sample k=3 -> DONE immediately, fill=3.
6. Restart/reset: arm during POST -> fill=0, stamp restarts at 0. arm during DUMP ignored. rst_n low mid-dump -> rd_valid=0, state=0 asynchronously.

Source files
------------

// File: rtl/trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trace_capture: circular retire-trace recorder with pre/post trigger window  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module trace_capture #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 16,
  parameter int STAMP_W   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 arm_i,
  input  logic                                 samp_valid_i,
  input  logic [CHANNELS*WIDTH-1:0]            samp_data_i,
  input  logic                                 trig_in_i,
  input  logic                                 dump_i,
  output logic                                 rd_valid_o,
  input  logic                                 rd_ready_i,
  output logic [STAMP_W+CHANNELS*WIDTH-1:0]    rd_data_o,
  output logic                                 rd_last_o,
  output logic [2:0]                           state_o,
  output logic [$clog2(DEPTH):0]               fill_o
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             DW   = STAMP_W + CHANNELS*WIDTH;
  localparam logic [AW:0]    FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_DONE  = 3'd3,
    S_DUMP  = 3'd4
  } state_e;

  state_e               state_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW-1:0]        post_cnt_q;
  logic [AW:0]          fill_q;
  logic [AW:0]          issue_left_q;
  logic [STAMP_W-1:0]   stamp_q;
  logic                 ram_vld_q;
  logic                 ram_last_q;
  logic                 rd_valid_q;
  logic                 rd_last_q;
  logic [DW-1:0]        rd_data_q;
  logic [DW-1:0]        ram_q;
  logic [DW-1:0]        mem [DEPTH];

  logic                 capturing;
  logic                 wr_en;
  logic                 trig;
  logic                 start_dump;
  logic                 out_free;
  logic                 move;
  logic                 issue;
  logic                 issue_last;
  logic                 final_xfer;
  logic [AW-1:0]        oldest;
  logic [AW-1:0]        rd_addr;

  assign capturing  = (state_q == S_ARMED) || (state_q == S_POST);
  assign wr_en      = capturing && samp_valid_i && !arm_i;
  assign trig       = (state_q == S_ARMED) && samp_valid_i && trig_in_i;
  assign oldest     = (fill_q == FULL) ? wr_ptr_q : '0;
  assign start_dump = (state_q == S_DONE) && dump_i && !arm_i;

  // ram_q is a one-entry prefetch stage in front of the output register;
  // refilling it on the same edge it drains keeps the stream bubble-free.
  assign out_free   = !rd_valid_q || rd_ready_i;
  assign move       = (state_q == S_DUMP) && ram_vld_q && out_free;
  assign issue      = start_dump ||
                      ((state_q == S_DUMP) && (issue_left_q != '0) && (!ram_vld_q || move));
  assign issue_last = start_dump ? (fill_q == (AW+1)'(1)) : (issue_left_q == (AW+1)'(1));
  assign rd_addr    = start_dump ? oldest : rd_ptr_q;
  assign final_xfer = rd_valid_q && rd_ready_i && rd_last_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {stamp_q, samp_data_i};
    if (issue) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      post_cnt_q   <= '0;
      fill_q       <= '0;
      issue_left_q <= '0;
      stamp_q      <= '0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        stamp_q  <= stamp_q + 1'b1;
        if (fill_q != FULL) fill_q <= fill_q + 1'b1;
      end

      if (issue) begin
        ram_vld_q    <= 1'b1;
        ram_last_q   <= issue_last;
        rd_ptr_q     <= rd_addr + 1'b1;
        issue_left_q <= (start_dump ? fill_q : issue_left_q) - 1'b1;
      end else if (move) begin
        ram_vld_q <= 1'b0;
      end

      if (move) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= ram_q;
        rd_last_q  <= ram_last_q;
      end else if (rd_valid_q && rd_ready_i) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (trig) begin
            if (POST_TRIG == 0) begin
              state_q <= S_DONE;
            end else begin
              state_q    <= S_POST;
              post_cnt_q <= AW'(POST_TRIG);
            end
          end
        end
        S_POST: begin
          if (samp_valid_i) begin
            post_cnt_q <= post_cnt_q - 1'b1;
            if (post_cnt_q == AW'(1)) state_q <= S_DONE;
          end
        end
        S_DONE: if (start_dump) state_q <= S_DUMP;
        S_DUMP: if (final_xfer) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Restart wins over everything except an in-flight dump.
      if (arm_i && (state_q != S_DUMP)) begin
        state_q  <= S_ARMED;
        fill_q   <= '0;
        wr_ptr_q <= '0;
        stamp_q  <= '0;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_last_o  = rd_last_q;
  assign state_o    = state_q;
  assign fill_o     = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trace_capture: vector table, directed corner cases and random capture    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_trace_capture;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm, samp_valid, trig_in, dump, rd_ready;
  logic [15:0] samp_data;
  logic        rd_valid, rd_last;
  logic [31:0] rd_data;
  logic [2:0]  state;
  logic [3:0]  fill;
  logic        rd_valid_z, rd_last_z;
  logic [31:0] rd_data_z;
  logic [2:0]  state_z;
  logic [3:0]  fill_z;

  int checks   = 0;
  int failures = 0;

  trace_capture #(.WIDTH(8), .CHANNELS(2), .DEPTH(DEPTH), .POST_TRIG(3), .STAMP_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .samp_valid_i(samp_valid), .samp_data_i(samp_data),
    .trig_in_i(trig_in), .dump_i(dump), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .state_o(state), .fill_o(fill)
  );

  trace_capture #(.WIDTH(8), .CHANNELS(2), .DEPTH(DEPTH), .POST_TRIG(0), .STAMP_W(16)) u_dut_p0 (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .samp_valid_i(samp_valid), .samp_data_i(samp_data),
    .trig_in_i(trig_in), .dump_i(dump), .rd_valid_o(rd_valid_z), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data_z), .rd_last_o(rd_last_z), .state_o(state_z), .fill_o(fill_z)
  );

  always #5 clk = ~clk;

  // Reference model: the captured window is simply the last DEPTH stored samples.
  logic [31:0] m_q[$];
  logic [15:0] m_stamp;
  int          m_state;
  int          m_post;

  typedef struct {
    logic        a;
    logic        sv;
    logic [15:0] d;
    logic        t;
    logic [2:0]  st;
    logic [3:0]  fl;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] exp_q[$];
  logic        ra, rsv, rt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stamp = '0;
    m_state = 0;
    m_post  = 0;
  endtask

  task automatic model_step(input logic a, input logic sv, input logic [15:0] d, input logic t);
    if (a && m_state != 4) begin
      m_q.delete();
      m_stamp = '0;
      m_state = 1;
    end else if ((m_state == 1 || m_state == 2) && sv) begin
      m_q.push_back({m_stamp, d});
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      m_stamp++;
      if (m_state == 1 && t) begin
        m_state = 2;
        m_post  = 3;
      end else if (m_state == 2) begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
    end
  endtask

  task automatic cycle(input logic a, input logic sv, input logic [15:0] d, input logic t);
    arm = a; samp_valid = sv; samp_data = d; trig_in = t;
    model_step(a, sv, d, t);
    tick();
    arm = 1'b0; samp_valid = 1'b0; trig_in = 1'b0;
  endtask

  // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready
  task automatic do_dump(input logic [31:0] exp[$], input int mode);
    int          cyc, n, k, first_cyc, last_cyc;
    logic        stalled;
    logic [31:0] prev_data;
    logic        prev_last;
    n = 0; k = 0; first_cyc = -1; last_cyc = -1; stalled = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    rd_ready = 1'b0;
    dump = 1'b1;
    tick();
    dump = 1'b0;
    cyc = 1;
    while (n < exp.size() && cyc < 200) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k % 3) == 0;
        default: rd_ready = 1'($urandom_range(1, 0));
      endcase
      k++;
      if (rd_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          chk("dump_latency", 64'(cyc <= 2), 64'(1));
        end
        if (stalled) begin
          chk("stall_data_stable", rd_data, prev_data);
          chk("stall_last_stable", rd_last, prev_last);
        end
        if (rd_ready) begin
          chk($sformatf("beat%0d_data", n), rd_data, exp[n]);
          chk($sformatf("beat%0d_last", n), rd_last, n == exp.size() - 1);
          n++;
          last_cyc = cyc;
          stalled  = 1'b0;
        end else begin
          stalled   = 1'b1;
          prev_data = rd_data;
          prev_last = rd_last;
        end
      end
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    chk("dump_beats_received", n, exp.size());
    if (mode == 0) chk("zero_bubble", last_cyc - first_cyc, exp.size() - 1);
    chk("post_dump_rd_valid", rd_valid, 0);
    chk("post_dump_state", state, 0);
    chk("post_dump_fill_kept", fill, exp.size());
    m_state = 0;
  endtask

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].a, tbl[i].sv, tbl[i].d, tbl[i].t);
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_fill", i), fill, tbl[i].fl);
    end
  endtask

  function automatic logic [31:0] mk(input int s, input logic [15:0] d);
    return {16'(s), d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 16'hEEEE, 1'b0, 3'd1, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd1, 4'd0};
    tbl[2] = '{1'b0, 1'b1, 16'h0101, 1'b0, 3'd1, 4'd1};
    tbl[3] = '{1'b0, 1'b1, 16'h0202, 1'b1, 3'd2, 4'd2};
    tbl[4] = '{1'b0, 1'b1, 16'h0303, 1'b0, 3'd2, 4'd3};
    tbl[5] = '{1'b0, 1'b1, 16'h0404, 1'b0, 3'd2, 4'd4};
    tbl[6] = '{1'b0, 1'b1, 16'h0505, 1'b0, 3'd3, 4'd5};
    tbl[7] = '{1'b0, 1'b1, 16'h0606, 1'b0, 3'd3, 4'd5};

    rst_n = 1'b0; arm = 1'b0; samp_valid = 1'b0; samp_data = '0;
    trig_in = 1'b0; dump = 1'b0; rd_ready = 1'b0;
    model_reset();
    tick(); tick();
    chk("reset_state", state, 0);
    chk("reset_fill", fill, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_last", rd_last, 0);
    chk("reset_rd_data", rd_data, 0);
    rst_n = 1'b1;

    // Idle: samples ignored, dump ignored
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 16'h1234, 1'b1);
    chk("idle_state", state, 0);
    chk("idle_fill", fill, 0);
    dump = 1'b1; tick(); dump = 1'b0; tick(); tick();
    chk("idle_dump_state", state, 0);
    chk("idle_dump_rd_valid", rd_valid, 0);

    // No wrap, streaming dump
    run_table();
    exp_q.delete();
    for (int k = 1; k <= 5; k++) exp_q.push_back(mk(k - 1, 16'(k) * 16'h0101));
    do_dump(exp_q, 0);

    // Backpressure on the same capture
    run_table();
    do_dump(exp_q, 1);

    // Wrap: trigger on stamp 20, window is stamps 16..23
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    for (int s = 0; s < 24; s++) cycle(1'b0, 1'b1, {8'(s) ^ 8'h5A, 8'(s)}, s == 20);
    chk("wrap_state", state, 3);
    chk("wrap_fill", fill, 8);
    exp_q.delete();
    for (int s = 16; s < 24; s++) exp_q.push_back(mk(s, {8'(s) ^ 8'h5A, 8'(s)}));
    do_dump(exp_q, 0);

    // Trigger qualification; POST_TRIG=0 instance freezes on the trigger sample
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    chk("trig_no_valid_state", state, 1);
    chk("p0_trig_no_valid_state", state_z, 1);
    for (int k = 1; k <= 3; k++) cycle(1'b0, 1'b1, 16'(k) * 16'h0101, k == 3);
    chk("p0_done_state", state_z, 3);
    chk("p0_done_fill", fill_z, 3);
    chk("p3_post_state", state, 2);
    cycle(1'b0, 1'b1, 16'h0404, 1'b0);
    chk("p0_frozen_fill", fill_z, 3);

    // Arm during POST restarts; stamps start from 0 again
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 16'hAAAA, 1'b1);
    cycle(1'b0, 1'b1, 16'hBBBB, 1'b0);
    chk("pre_rearm_state", state, 2);
    cycle(1'b1, 1'b1, 16'hCCCC, 1'b0);
    chk("rearm_state", state, 1);
    chk("rearm_fill", fill, 0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 16'hD000 + 16'(k), k == 0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(k, 16'hD000 + 16'(k)));
    do_dump(exp_q, 0);

    // Arm during DUMP ignored, then reset mid-dump
    run_table();
    rd_ready = 1'b0;
    dump = 1'b1; tick(); dump = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_in_dump_state", state, 4);
    tick(); tick();
    chk("held_rd_valid", rd_valid, 1);
    chk("held_rd_data", rd_data, mk(0, 16'h0101));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd_valid", rd_valid, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_fill", fill, 0);
    chk("async_rst_rd_data", rd_data, 0);
    tick();
    rst_n = 1'b1;
    model_reset();

    // Random capture sessions against the window model
    for (int it = 0; it < 8; it++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
      for (int c = 0; c < 60 && m_state != 3; c++) begin
        ra  = ($urandom % 50) == 0;
        rsv = ($urandom % 10) < 7;
        rt  = ($urandom % 12) == 0;
        cycle(ra, rsv, 16'($urandom), rt);
        chk("rnd_state", state, m_state);
        chk("rnd_fill", fill, m_q.size());
      end
      if (m_state == 3) do_dump(m_q, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
